// File: rtl/riscv_core_16booth_iter_mul.sv
// riscv_core_16booth_iter_mul
//   Iterative radix-16 Booth multiplier for the RV64 M-extension MUL/MULH/
//   MULHSU/MULHU ops. An external combinational Booth encoder receives the
//   latched, one-bit-extended multiplicand and one 5-bit multiplier group per
//   cycle. It returns the matching signed partial product on the same cycle.
//   Seventeen partial products are accumulated, with a 4-bit arithmetic right
//   shift per cycle. The low or high XLEN half is then returned over a
//   valid/ready handshake.
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_valid/o_ready       request handshake (i_op, i_rs1, i_rs2)
//   i_flush               abort the current operation
//   o_valid/i_ready       result handshake (o_result)
//   o_busy                an operation is in flight or waiting to be consumed
//   o_enc_muld/o_enc_sel  to the Booth encoder
//   i_enc_pp              partial product from the Booth encoder
module riscv_core_16booth_iter_mul #(
    parameter int XLEN = 64
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [1:0]             i_op,
    input  logic [XLEN-1:0]        i_rs1,
    input  logic [XLEN-1:0]        i_rs2,
    input  logic                   i_flush,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [XLEN-1:0]        o_result,
    output logic                   o_busy,
    output logic [XLEN:0]          o_enc_muld,
    output logic [4:0]             o_enc_sel,
    input  logic signed [XLEN+3:0] i_enc_pp
);

    localparam int MW   = XLEN + 5;        // multiplier register / accumulator high part
    localparam int LW   = XLEN + 4;        // accumulator low part
    localparam int NGRP = (XLEN + 4) / 4;  // Booth groups per operation
    localparam int CW   = $clog2(NGRP + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]      res_q, res_d;
    logic [XLEN:0]        muld_q;
    logic [1:0]           op_q;
    logic signed [MW-1:0] m_q;
    logic signed [MW-1:0] h_q;
    logic [LW-1:0]        l_q;

    logic                    accept;
    logic [XLEN:0]           rs1_ext, rs2_ext;
    logic signed [MW-1:0]    m_init;
    logic signed [MW-1:0]    pp_ext, sum;
    logic signed [MW+LW-1:0] hl_cat, hl_sh;

    function automatic logic [XLEN-1:0] sel_half(input logic [1:0] op,
                                                 input logic [2*XLEN-1:0] p);
        return (op == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    assign accept = (state_q == IDLE) && i_valid && !i_flush;

    // rs1 is unsigned only for MULHU; rs2 is unsigned for MULHSU and MULHU.
    assign rs1_ext = {(i_op != 2'b11) & i_rs1[XLEN-1], i_rs1};
    assign rs2_ext = {~i_op[1] & i_rs2[XLEN-1], i_rs2};
    // Implicit zero below the LSB feeds the first Booth group.
    // The sign tail on top lets the last group see a valid window.
    assign m_init  = {{3{rs2_ext[XLEN]}}, rs2_ext, 1'b0};

    assign pp_ext = {i_enc_pp[XLEN+3], i_enc_pp};
    assign sum    = h_q + pp_ext;
    assign hl_cat = {sum, l_q};
    assign hl_sh  = hl_cat >>> 4;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (i_flush) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(NGRP - 1)) begin
                        state_d = DONE;
                        res_d   = sel_half(op_q, hl_sh[2*XLEN-1:0]);
                    end
                end
            end
            DONE: begin
                if (i_flush || i_ready) begin
                    state_d = IDLE;
                    res_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                res_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            muld_q  <= '0;
            op_q    <= '0;
            m_q     <= '0;
            h_q     <= '0;
            l_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            if (accept) begin
                muld_q <= rs1_ext;
                op_q   <= i_op;
                m_q    <= m_init;
                h_q    <= '0;
                l_q    <= '0;
            end else if (state_q == RUN) begin
                h_q <= hl_sh[MW+LW-1:LW];
                l_q <= hl_sh[LW-1:0];
                m_q <= m_q >>> 4;
            end
        end
    end

    assign o_ready    = (state_q == IDLE);
    assign o_valid    = (state_q == DONE);
    assign o_busy     = (state_q != IDLE);
    assign o_result   = res_q;
    assign o_enc_muld = muld_q;
    // The encoder outputs zero outside RUN because the select is forced to 0.
    assign o_enc_sel  = (state_q == RUN) ? m_q[4:0] : 5'd0;

endmodule

// File: tb/tb_riscv_core_16booth_iter_mul.sv
module tb_riscv_core_16booth_iter_mul;

    localparam int XLEN = 64;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   i_valid;
    logic                   o_ready;
    logic [1:0]             i_op;
    logic [XLEN-1:0]        i_rs1, i_rs2;
    logic                   i_flush;
    logic                   o_valid;
    logic                   i_ready;
    logic [XLEN-1:0]        o_result;
    logic                   o_busy;
    logic [XLEN:0]          enc_muld;
    logic [4:0]             enc_sel;
    logic signed [XLEN+3:0] enc_pp;

    int total = 0;
    int bad   = 0;

    logic [4:0]      sel_first, sel_or;
    logic [XLEN-1:0] hold;

    always #5 clk = ~clk;

    riscv_core_16booth_iter_mul #(.XLEN(XLEN)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_op(i_op), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_flush(i_flush),
        .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
        .o_busy(o_busy), .o_enc_muld(enc_muld), .o_enc_sel(enc_sel),
        .i_enc_pp(enc_pp)
    );

    // Radix-16 Booth encoder: digit = -8*b4 + 4*b3 + 2*b2 + b1 + b0, times multiplicand.
    int                     enc_d;
    logic signed [XLEN+3:0] md_x, dg_x;
    always_comb begin
        enc_d  = (enc_sel[0] ? 1 : 0) + (enc_sel[1] ? 1 : 0) + (enc_sel[2] ? 2 : 0)
               + (enc_sel[3] ? 4 : 0) - (enc_sel[4] ? 8 : 0);
        md_x   = {{3{enc_muld[XLEN]}}, enc_muld};
        dg_x   = (XLEN + 4)'(enc_d);
        enc_pp = md_x * dg_x;
    end

    function automatic logic [XLEN-1:0] ref_mul(input logic [1:0] op,
                                                input logic [XLEN-1:0] a, b);
        logic [2*XLEN-1:0] xa, xb, p;
        xa = {{XLEN{a[XLEN-1] & (op != 2'b11)}}, a};
        xb = {{XLEN{b[XLEN-1] & ~op[1]}}, b};
        p  = xa * xb;
        return (op == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // Issue one op, wait for o_valid, optionally stall i_ready, then consume.
    task automatic do_op(input logic [1:0] op, input logic [XLEN-1:0] a, b,
                         input int stall, input bit poke,
                         output logic [XLEN-1:0] res, output int lat);
        int w;
        w = 0;
        while (!o_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        i_op = op; i_rs1 = a; i_rs2 = b; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid   = 1'b0;
        sel_first = enc_sel;
        sel_or    = '0;
        lat       = 0;
        while (!o_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            sel_or |= enc_sel;
        end
        hold = o_result;
        for (int k = 0; k < stall; k++) begin
            i_valid = poke;
            @(posedge clk); #1;
            chk("hold_valid", {63'd0, o_valid}, 64'd1);
            chk("hold_result", o_result, hold);
            if (poke) chk("hold_ready", {63'd0, o_ready}, 64'd0);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
        res = hold;
    endtask

    typedef struct {
        logic [1:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] exp;
    } vec_t;

    vec_t            tbl[11];
    logic [XLEN-1:0] res;
    int              lat;
    logic [XLEN-1:0] corner[5];
    logic [XLEN-1:0] ra, rb;
    logic [1:0]      rop;
    bit              seen_valid;

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{2'b00, 64'd3, 64'd5, 64'd15};
        tbl[1]  = '{2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000};
        tbl[2]  = '{2'b00, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0};
        tbl[3]  = '{2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE};
        tbl[4]  = '{2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[5]  = '{2'b00, 64'd6, 64'd7, 64'd42};
        tbl[6]  = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
        tbl[7]  = '{2'b11, 64'h8000_0000_0000_0000, 64'd2, 64'd1};
        tbl[8]  = '{2'b01, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'h3FFF_FFFF_FFFF_FFFF};
        tbl[9]  = '{2'b10, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'hC000_0000_0000_0000};
        tbl[10] = '{2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'hFFFF_FFFF_FFFF_FFFB};
        corner = '{64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF};

        rst = 1'b1; i_valid = 1'b0; i_op = '0; i_rs1 = '0; i_rs2 = '0;
        i_flush = 1'b0; i_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_valid", {63'd0, o_valid}, 64'd0);
        chk("rst_busy", {63'd0, o_busy}, 64'd0);
        chk("rst_ready", {63'd0, o_ready}, 64'd1);
        chk("rst_result", o_result, 64'd0);
        chk("rst_sel", {59'd0, enc_sel}, 64'd0);

        // T1 with latency and encoder select sequence
        do_op(tbl[0].op, tbl[0].a, tbl[0].b, 0, 1'b0, res, lat);
        chk("t1_result", res, tbl[0].exp);
        chk("t1_latency", 64'(lat), 64'd17);
        chk("t1_sel_first", {59'd0, sel_first}, 64'h0A);
        chk("t1_sel_rest", {59'd0, sel_or}, 64'd0);
        chk("t1_idle_after", {63'd0, o_busy}, 64'd0);

        for (int i = 1; i < 11; i++) begin
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, 0, 1'b0, res, lat);
            chk($sformatf("vec%0d_result", i), res, tbl[i].exp);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd17);
        end

        // T4: backpressure with a competing request
        do_op(2'b00, -64'sd7, -64'sd3, 5, 1'b1, res, lat);
        chk("t4_result", res, 64'd21);
        @(posedge clk); #1;
        chk("t4_not_accepted", {63'd0, o_busy}, 64'd0);

        // T5: flush on the 8th RUN cycle, then the same with reset
        for (int mode = 0; mode < 2; mode++) begin
            i_op = 2'b00; i_rs1 = 64'd9; i_rs2 = 64'd11; i_valid = 1'b1;
            @(posedge clk); #1;
            i_valid = 1'b0;
            repeat (7) begin @(posedge clk); #1; end
            if (mode == 0) i_flush = 1'b1; else rst = 1'b1;
            @(posedge clk); #1;
            i_flush = 1'b0; rst = 1'b0;
            chk($sformatf("t5_%0d_busy", mode), {63'd0, o_busy}, 64'd0);
            chk($sformatf("t5_%0d_ready", mode), {63'd0, o_ready}, 64'd1);
            chk($sformatf("t5_%0d_result", mode), o_result, 64'd0);
            chk($sformatf("t5_%0d_sel", mode), {59'd0, enc_sel}, 64'd0);
            seen_valid = 1'b0;
            repeat (20) begin @(posedge clk); #1; seen_valid |= o_valid; end
            chk($sformatf("t5_%0d_no_valid", mode), {63'd0, seen_valid}, 64'd0);
            do_op(2'b00, 64'd6, 64'd7, 0, 1'b0, res, lat);
            chk($sformatf("t5_%0d_after", mode), res, 64'd42);
        end

        // Flush while DONE discards the result
        i_op = 2'b00; i_rs1 = 64'd2; i_rs2 = 64'd2; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (17) begin @(posedge clk); #1; end
        chk("done_flush_pre", {63'd0, o_valid}, 64'd1);
        i_flush = 1'b1;
        @(posedge clk); #1;
        i_flush = 1'b0;
        chk("done_flush_valid", {63'd0, o_valid}, 64'd0);
        chk("done_flush_result", o_result, 64'd0);

        // Flush has priority over a request in IDLE
        i_valid = 1'b1; i_flush = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0; i_flush = 1'b0;
        chk("idle_flush_prio", {63'd0, o_busy}, 64'd0);

        // T6: random ops against the 128-bit model
        for (int n = 0; n < 2000; n++) begin
            ra  = ($urandom_range(0, 1) == 0) ? corner[$urandom_range(0, 4)] : {$urandom, $urandom};
            rb  = ($urandom_range(0, 1) == 0) ? corner[$urandom_range(0, 4)] : {$urandom, $urandom};
            rop = 2'($urandom_range(0, 3));
            do_op(rop, ra, rb, $urandom_range(0, 3), 1'b0, res, lat);
            chk($sformatf("rnd%0d_op%0d", n, rop), res, ref_mul(rop, ra, rb));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
